// File: rtl/seg7_scan_driver_if.sv
// Bundle of the display-side signals of seg7_scan_driver.
//   master : the controller that loads glyph codes and masks, and sees the scan outputs
//   slave  : the scan driver itself
// Signals:
//   load        capture codes/blink_mask/blank_mask into the driver's shadow registers
//   codes       4 bits per digit; digit i at [4i+3:4i]
//   blink_mask  bit i set: digit i blinks
//   blank_mask  bit i set: digit i forced dark
//   an          anode enables, active-low, at most one bit low
//   seg         segments, active-low, bit 6 = A ... bit 0 = G
//   frame_done  one-cycle pulse after the scan wraps back to digit 0
interface seg7_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
) ();

  logic                    load;
  logic [4*NUM_DIGITS-1:0] codes;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    frame_done;

  modport master (
    output load, codes, blink_mask, blank_mask,
    input  an, seg, frame_done
  );

  modport slave (
    input  load, codes, blink_mask, blank_mask,
    output an, seg, frame_done
  );

endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with per-digit blink and blank.
// Ports:
//   clk    single system clock, rising edge
//   reset  synchronous, active-high
//   bus    seg7_scan_driver_if.slave: load/codes/blink_mask/blank_mask in,
//          an/seg/frame_done out (all outputs registered, one-cycle latency)
// Each digit is driven for REFRESH_DIV cycles; blinking digits go dark while
// blink_phase is 1, which toggles every BLINK_DIV cycles.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input logic               clk,
  input logic               reset,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned RefW   = $clog2(REFRESH_DIV);
  localparam int unsigned BlinkW = $clog2(BLINK_DIV);
  localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [6:0] SegDark = 7'b1111111;

  // Glyph decode, active-low, bit 6 = A ... bit 0 = G.
  function automatic logic [6:0] decode_glyph(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      4'd10:   s = 7'b0001001; // up
      4'd11:   s = 7'b1000001; // down
      4'd12:   s = 7'b1111110; // neutral dash
      default: s = SegDark;
    endcase
    return s;
  endfunction

  // Counters and scan position
  logic [RefW-1:0]   refresh_cnt_q, refresh_cnt_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              blink_phase_q, blink_phase_d;

  // Shadow copies of the display inputs
  logic [4*NUM_DIGITS-1:0] shadow_codes_q, shadow_codes_d;
  logic [NUM_DIGITS-1:0]   shadow_blink_q, shadow_blink_d;
  logic [NUM_DIGITS-1:0]   shadow_blank_q, shadow_blank_d;

  // Registered outputs
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  frame_done_q, frame_done_d;

  // Decode helpers
  logic       refresh_wrap;
  logic       scan_wrap;
  logic       blink_wrap;
  logic [3:0] cur_code;
  logic       cur_blink;
  logic       cur_blank;

  always_comb begin
    refresh_wrap = (refresh_cnt_q == RefW'(REFRESH_DIV - 1));
    scan_wrap    = (idx_q == IdxW'(NUM_DIGITS - 1));
    blink_wrap   = (blink_cnt_q == BlinkW'(BLINK_DIV - 1));

    refresh_cnt_d = refresh_wrap ? '0 : refresh_cnt_q + 1'b1;
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;

    idx_d = idx_q;
    if (refresh_wrap) begin
      idx_d = scan_wrap ? '0 : idx_q + 1'b1;
    end

    // Outputs are built from the pre-edge scan index and shadow contents,
    // which gives the one-cycle output latency.
    cur_code  = 4'hF;
    cur_blink = 1'b0;
    cur_blank = 1'b0;
    an_d      = '1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_code  = shadow_codes_q[4*i +: 4];
        cur_blink = shadow_blink_q[i];
        cur_blank = shadow_blank_q[i];
        an_d[i]   = 1'b0;
      end
    end

    // Blank wins over blink; the anode still cycles for dark digits.
    if (cur_blank || (cur_blink && blink_phase_q)) begin
      seg_d = SegDark;
    end else begin
      seg_d = decode_glyph(cur_code);
    end

    frame_done_d = refresh_wrap && scan_wrap;

    shadow_codes_d = bus.load ? bus.codes      : shadow_codes_q;
    shadow_blink_d = bus.load ? bus.blink_mask : shadow_blink_q;
    shadow_blank_d = bus.load ? bus.blank_mask : shadow_blank_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt_q  <= '0;
      blink_cnt_q    <= '0;
      idx_q          <= '0;
      blink_phase_q  <= 1'b0;
      shadow_codes_q <= '1;
      shadow_blink_q <= '0;
      shadow_blank_q <= '0;
      an_q           <= '1;
      seg_q          <= SegDark;
      frame_done_q   <= 1'b0;
    end else begin
      refresh_cnt_q  <= refresh_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      idx_q          <= idx_d;
      blink_phase_q  <= blink_phase_d;
      shadow_codes_q <= shadow_codes_d;
      shadow_blink_q <= shadow_blink_d;
      shadow_blank_q <= shadow_blank_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clk cycles each digit is driven (legal >= 2).
REQ-003 SHALL have parameter BLINK_DIV, default 25000000, clk cycles per blink half-period (legal >= 2).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port load  input  1  capture codes, blink_mask and blank_mask into the shadow registers.
REQ-007 SHALL have port codes  input  4*NUM_DIGITS  per-digit glyph code; digit i at bits [4i+3:4i].
REQ-008 SHALL have port blink_mask  input  NUM_DIGITS  bit i set: digit i blinks.
REQ-009 SHALL have port blank_mask  input  NUM_DIGITS  bit i set: digit i forced dark.
REQ-010 SHALL have port an  output  NUM_DIGITS  anode enables, active-low, at most one bit low.
REQ-011 SHALL have port seg  output  7  segments, active-low, bit 6 = A ... bit 0 = G.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse when the scan wraps to digit 0.

Function
REQ-013 SHALL decode glyphs (A..G, active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-014 SHALL decode elevator glyphs: 10 (up)=0001001, 11 (down)=1000001, 12 (neutral dash)=1111110; codes 13, 14, 15 = 1111111 (dark).
REQ-015 SHALL latch all three inputs into shadow registers on any clk edge with load=1; display uses only shadow contents.
REQ-016 SHALL keep a refresh counter 0..REFRESH_DIV-1; on reaching REFRESH_DIV-1 it wraps to 0 and the scan index advances by one.
REQ-017 SHALL wrap scan index from NUM_DIGITS-1 to 0; frame_done is high for exactly the one cycle after that wrap edge.
REQ-018 SHALL register an and seg: both reflect the scan index and shadow state of the previous clk edge (one-cycle latency).
REQ-019 SHALL drive an as one-hot-low with bit[index]=0, all others 1.
REQ-020 SHALL keep a blink counter 0..BLINK_DIV-1 toggling blink_phase on each wrap; blink_phase starts at 0.
REQ-021 SHALL output seg=1111111 for the active digit when its blank bit is set, or when its blink bit is set and blink_phase=1; otherwise the decoded glyph.
REQ-022 SHALL give blank precedence over blink; anode still cycles normally for dark digits.
REQ-023 SHALL apply a load coinciding with a scan advance: the new digit uses the newly loaded shadow value on the following cycle.
REQ-024 SHALL not reset or restart the refresh, scan, or blink counters on load.
REQ-025 SHALL, with NUM_DIGITS=1, hold an=0 permanently after reset and pulse frame_done every REFRESH_DIV cycles.

Reset
REQ-026 SHALL, on clk edge with reset=1, set refresh counter, blink counter, scan index, blink_phase to 0, shadow codes to 15, shadow masks to 0.
REQ-027 SHALL drive an=all ones, seg=1111111, frame_done=0 in the cycle following a reset edge.
REQ-028 SHALL give reset priority over load; a reset mid-scan abandons the current frame with no frame_done pulse.
REQ-029 SHALL drive digit 0 (an bit 0 low) in the second cycle after reset deasserts.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=16)
REQ-030 SHALL verify: reset, load codes=16'h3210 -> an cycles 1110,1101,1011,0111 every 4 cycles; seg 0000001,1001111,0010010,0000110; frame_done once per 16 cycles.
REQ-031 SHALL verify: load codes=16'hCB0A -> digits show up 0001001, 0 0000001, down 1000001, dash 1111110; codes 13/14/15 give 1111111.
REQ-032 SHALL verify: blink_mask=0001, codes digit0=8 -> digit 0 seg alternates 0000000 / 1111111 every 16 cycles; other digits unaffected.
REQ-033 SHALL verify: blank_mask=0010 with blink_mask=0010 -> digit 1 always 1111111 while an bit 1 still goes low in its slot.
REQ-034 SHALL verify: load asserted on the scan-advance edge into digit 2 -> digit 2 shows the new code on its first displayed cycle.
REQ-035 SHALL verify: reset asserted while digit 2 active -> next cycle an=1111, seg=1111111, no frame_done; scan resumes at digit 0.
